// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit that owns the HI/LO register pair.
// Optional commit tracing is enabled by defining MDU_TRACE_EN.
module mul_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        mf_sel,
    input  logic [31:0] PC,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] md_rd
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t        state_reg;
    logic [CW-1:0] count_reg;
    logic [63:0]   pending_reg;
    logic          commit_reg;
    logic          busy_reg;
    logic [31:0]   hi_reg;
    logic [31:0]   lo_reg;

    // Products computed on the full 64-bit width so the low 64 bits are exact.
    logic [63:0] a_sext, b_sext, mult_s, mult_u;
    assign a_sext = {{32{rs_val[31]}}, rs_val};
    assign b_sext = {{32{rt_val[31]}}, rt_val};
    assign mult_s = a_sext * b_sext;
    assign mult_u = {32'd0, rs_val} * {32'd0, rt_val};

    // Signed divide through magnitudes; avoids the -2^31 / -1 overflow case.
    logic        a_neg, b_neg, div_zero;
    logic [31:0] a_mag, b_mag, b_mag_safe, rt_safe;
    logic [31:0] q_mag, r_mag, q_s, r_s, q_u, r_u;
    assign a_neg      = rs_val[31];
    assign b_neg      = rt_val[31];
    assign a_mag      = a_neg ? -rs_val : rs_val;
    assign b_mag      = b_neg ? -rt_val : rt_val;
    assign div_zero   = (rt_val == 32'd0);
    assign b_mag_safe = div_zero ? 32'd1 : b_mag;
    assign rt_safe    = div_zero ? 32'd1 : rt_val;
    assign q_mag      = a_mag / b_mag_safe;
    assign r_mag      = a_mag % b_mag_safe;
    assign q_s        = (a_neg ^ b_neg) ? -q_mag : q_mag;
    assign r_s        = a_neg ? -r_mag : r_mag;
    assign q_u        = rs_val / rt_safe;
    assign r_u        = rs_val % rt_safe;

`ifdef MDU_TRACE_EN
    logic [31:0] pc_reg;
`else
    logic unused_pc;
    assign unused_pc = ^PC;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            count_reg   <= '0;
            pending_reg <= '0;
            commit_reg  <= 1'b0;
            busy_reg    <= 1'b0;
            hi_reg      <= '0;
            lo_reg      <= '0;
`ifdef MDU_TRACE_EN
            pc_reg      <= '0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
`ifdef MDU_TRACE_EN
                        pc_reg <= PC;
`endif
                        case (md_op)
                            OP_MULT, OP_MULTU: begin
                                state_reg   <= MUL;
                                busy_reg    <= 1'b1;
                                count_reg   <= CW'(MULT_CYCLES);
                                pending_reg <= (md_op == OP_MULT) ? mult_s : mult_u;
                                commit_reg  <= 1'b1;
                            end
                            OP_DIV, OP_DIVU: begin
                                state_reg   <= DIV;
                                busy_reg    <= 1'b1;
                                count_reg   <= CW'(DIV_CYCLES);
                                pending_reg <= (md_op == OP_DIV) ? {r_s, q_s} : {r_u, q_u};
                                commit_reg  <= !div_zero;
                            end
                            OP_MTHI: begin
                                hi_reg <= rs_val;
`ifdef MDU_TRACE_EN
                                $display("@%h: $hi <= %h", PC, rs_val);
`endif
                            end
                            OP_MTLO: begin
                                lo_reg <= rs_val;
`ifdef MDU_TRACE_EN
                                $display("@%h: $lo <= %h", PC, rs_val);
`endif
                            end
                            default: ;
                        endcase
                    end
                end
                MUL, DIV: begin
                    if (count_reg == CW'(1)) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                        count_reg <= '0;
                        if (commit_reg) begin
                            hi_reg <= pending_reg[63:32];
                            lo_reg <= pending_reg[31:0];
`ifdef MDU_TRACE_EN
                            $display("@%h: $hi <= %h", pc_reg, pending_reg[63:32]);
                            $display("@%h: $lo <= %h", pc_reg, pending_reg[31:0]);
`endif
                        end
                    end else begin
                        count_reg <= count_reg - CW'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy  = busy_reg;
    assign stall = busy_reg | (start & (md_op >= OP_MULT) & (md_op <= OP_MTLO));
    assign hi    = hi_reg;
    assign lo    = lo_reg;
    assign md_rd = mf_sel ? hi_reg : lo_reg;

endmodule

// File: tb/tb_mul_div_unit.sv
// Randomized self-checking bench for mul_div_unit against an arithmetic reference model.
module tb_mul_div_unit;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  md_op = 4'd0;
    logic [31:0] rs_val = '0;
    logic [31:0] rt_val = '0;
    logic        mf_sel = 1'b0;
    logic [31:0] PC = '0;
    logic        busy, stall;
    logic [31:0] hi, lo, md_rd;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    mul_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .start(start), .md_op(md_op),
        .rs_val(rs_val), .rt_val(rt_val), .mf_sel(mf_sel), .PC(PC),
        .busy(busy), .stall(stall), .hi(hi), .lo(lo), .md_rd(md_rd)
    );

    always #5 clk = ~clk;

    // Reference: plain 64-bit arithmetic on the architectural rules.
    task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, p, q, r;
        longint unsigned ua, ub, up, uq, ur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            4'd1: begin p = sa * sb; exp_hi = p[63:32]; exp_lo = p[31:0]; end
            4'd2: begin up = ua * ub; exp_hi = up[63:32]; exp_lo = up[31:0]; end
            4'd3: if (b != 0) begin q = sa / sb; r = sa % sb; exp_lo = q[31:0]; exp_hi = r[31:0]; end
            4'd4: if (b != 0) begin uq = ua / ub; ur = ua % ub; exp_lo = uq[31:0]; exp_hi = ur[31:0]; end
            4'd5: exp_hi = a;
            4'd6: exp_lo = a;
            default: ;
        endcase
    endtask

    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input string name);
        logic [31:0] old_hi, old_lo;
        logic exp_stall;
        int n;
        old_hi = exp_hi;
        old_lo = exp_lo;
        n = (op == 4'd1 || op == 4'd2) ? MC : ((op == 4'd3 || op == 4'd4) ? DC : 0);
        exp_stall = (op >= 4'd1 && op <= 4'd6);
        @(negedge clk);
        start = 1'b1; md_op = op; rs_val = a; rt_val = b; PC = $urandom;
        #1;
        checks++;
        if (stall !== exp_stall) begin
            failures++;
            $display("FAIL %s stall got=%b exp=%b", name, stall, exp_stall);
        end
        model(op, a, b);
        @(negedge clk);
        start = 1'b0; md_op = 4'd0;
        for (int i = 0; i < n; i++) begin
            checks++;
            if (busy !== 1'b1 || hi !== old_hi || lo !== old_lo) begin
                failures++;
                $display("FAIL %s busy_cycle%0d busy=%b hi=%h lo=%h exp busy=1 hi=%h lo=%h",
                         name, i + 1, busy, hi, lo, old_hi, old_lo);
            end
            @(negedge clk);
        end
        mf_sel = $urandom_range(0, 1);
        #1;
        checks++;
        if (busy !== 1'b0 || hi !== exp_hi || lo !== exp_lo || md_rd !== (mf_sel ? exp_hi : exp_lo)) begin
            failures++;
            $display("FAIL %s result busy=%b hi=%h lo=%h md_rd=%h exp busy=0 hi=%h lo=%h",
                     name, busy, hi, lo, md_rd, exp_hi, exp_lo);
        end
        $display("op=%0d %s a=%h b=%h -> hi=%h lo=%h", op, name, a, b, hi, lo);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0 || stall !== 1'b0) begin
            failures++;
            $display("FAIL reset hi=%h lo=%h busy=%b stall=%b exp all zero", hi, lo, busy, stall);
        end
        reset = 1'b1;
        exp_hi = '0;
        exp_lo = '0;
        $display("reset released");
    endtask

    task automatic test_mt();
        run_op(4'd5, 32'h12345678, 32'd0, "mthi");
        run_op(4'd6, 32'h9ABCDEF0, 32'd0, "mtlo");
        mf_sel = 1'b1; #1;
        checks++;
        if (md_rd !== 32'h12345678) begin
            failures++;
            $display("FAIL md_rd_hi got=%h exp=%h", md_rd, 32'h12345678);
        end
        mf_sel = 1'b0; #1;
        checks++;
        if (md_rd !== 32'h9ABCDEF0) begin
            failures++;
            $display("FAIL md_rd_lo got=%h exp=%h", md_rd, 32'h9ABCDEF0);
        end
    endtask

    task automatic test_mult();
        run_op(4'd1, 32'hFFFFFFFE, 32'd3, "mult_fixed");
        run_op(4'd2, 32'hFFFFFFFE, 32'd3, "multu_fixed");
        for (int i = 0; i < 6; i++)
            run_op(4'($urandom_range(1, 2)), $urandom, $urandom, "mult_rand");
    endtask

    task automatic test_div();
        logic [31:0] d;
        run_op(4'd3, 32'hFFFFFFF9, 32'd2, "div_fixed");
        run_op(4'd5, 32'd1, 32'd0, "mthi_pre");
        run_op(4'd6, 32'd2, 32'd0, "mtlo_pre");
        run_op(4'd4, 32'd7, 32'd0, "divu_zero");
        run_op(4'd3, 32'h80000000, 32'hFFFFFFFF, "div_ovf");
        run_op(4'd3, $urandom, 32'd0, "div_zero");
        for (int i = 0; i < 8; i++) begin
            case ($urandom_range(0, 3))
                0:       d = 32'd0;
                1:       d = 32'($signed($urandom_range(0, 16)) - 8);
                default: d = $urandom;
            endcase
            run_op(4'($urandom_range(3, 4)), $urandom, d, "div_rand");
        end
    endtask

    task automatic test_invalid_op();
        logic [3:0] op;
        for (int i = 0; i < 4; i++) begin
            op = (i == 0) ? 4'd0 : 4'($urandom_range(7, 15));
            run_op(op, $urandom, $urandom, "no_op");
        end
    endtask

    task automatic test_busy_ignore();
        @(negedge clk);
        start = 1'b1; md_op = 4'd1; rs_val = 32'd2; rt_val = 32'd3;
        @(negedge clk);
        start = 1'b0; md_op = 4'd0;
        @(negedge clk);
        start = 1'b1; md_op = 4'd6; rs_val = 32'hAA;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            failures++;
            $display("FAIL ignore_stall got=%b exp=1", stall);
        end
        @(negedge clk);
        md_op = 4'd3; rs_val = 32'd100; rt_val = 32'd7;
        @(negedge clk);
        start = 1'b0; md_op = 4'd0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || lo !== exp_lo) begin
            failures++;
            $display("FAIL ignore_mid busy=%b lo=%h exp busy=1 lo=%h", busy, lo, exp_lo);
        end
        exp_hi = 32'd0;
        exp_lo = 32'd6;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || hi !== exp_hi || lo !== exp_lo) begin
            failures++;
            $display("FAIL ignore_result busy=%b hi=%h lo=%h exp busy=0 hi=%h lo=%h", busy, hi, lo, exp_hi, exp_lo);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || lo !== exp_lo) begin
            failures++;
            $display("FAIL ignore_after busy=%b lo=%h exp busy=0 lo=%h", busy, lo, exp_lo);
        end
        $display("busy_ignore mult 2*3 -> hi=%h lo=%h", hi, lo);
    endtask

    task automatic test_reset_midop();
        @(negedge clk);
        start = 1'b1; md_op = 4'd1; rs_val = 32'd5; rt_val = 32'd5;
        @(negedge clk);
        start = 1'b0; md_op = 4'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        exp_hi = '0;
        exp_lo = '0;
        checks++;
        if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid hi=%h lo=%h busy=%b exp all zero", hi, lo, busy);
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (MC + 2) @(negedge clk);
        checks++;
        if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_no_commit hi=%h lo=%h busy=%b exp all zero", hi, lo, busy);
        end
        $display("reset_midop mult 5*5 aborted -> hi=%h lo=%h", hi, lo);
    endtask

    initial begin
        test_reset();
        test_mt();
        test_mult();
        test_div();
        test_invalid_op();
        test_busy_ignore();
        test_reset_midop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
